// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multicycle control: opcodes, ALU mode, mux selects,
// control-FSM states and the opcode classes produced by deco_opcode.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_LUI    = 7'd55;

    localparam logic [1:0] MODO_SUMA    = 2'b00;
    localparam logic [1:0] MODO_OP_IMM  = 2'b01;
    localparam logic [1:0] MODO_OP      = 2'b10;
    localparam logic [1:0] MODO_RAMA    = 2'b11;

    localparam logic [1:0] SEL_A_PC     = 2'b00;
    localparam logic [1:0] SEL_A_PC_ANT = 2'b01;
    localparam logic [1:0] SEL_A_RS1    = 2'b10;
    localparam logic [1:0] SEL_A_CERO   = 2'b11;

    localparam logic [1:0] SEL_B_RS2    = 2'b00;
    localparam logic [1:0] SEL_B_IMM    = 2'b01;
    localparam logic [1:0] SEL_B_CUATRO = 2'b10;

    localparam logic [1:0] SEL_RES_ALU_REG = 2'b00;
    localparam logic [1:0] SEL_RES_MEM     = 2'b01;
    localparam logic [1:0] SEL_RES_ALU     = 2'b10;

    typedef enum logic [3:0] {
        ST_INICIO    = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC_R    = 4'd7,
        ST_EXEC_I    = 4'd8,
        ST_LUI       = 4'd9,
        ST_JAL       = 4'd10,
        ST_ALU_WB    = 4'd11,
        ST_BRANCH    = 4'd12,
        ST_TRAMPA    = 4'd13
    } estado_e;

    typedef enum logic [2:0] {
        CLASE_LOAD   = 3'd0,
        CLASE_STORE  = 3'd1,
        CLASE_R      = 3'd2,
        CLASE_I      = 3'd3,
        CLASE_BRANCH = 3'd4,
        CLASE_JAL    = 3'd5,
        CLASE_LUI    = 3'd6,
        CLASE_ILEGAL = 3'd7
    } clase_e;

endpackage

// File: rtl/unidad_control_multiciclo_deco_opcode.sv
// Combinational opcode classifier feeding the control FSM's DECODE and MEM_ADDR branches.
module deco_opcode
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_i,
    output clase_e     clase_o,
    output logic       ilegal_o
);

    always_comb begin
        clase_o = CLASE_ILEGAL;
        unique case (opcode_i)
            OP_LOAD:   clase_o = CLASE_LOAD;
            OP_STORE:  clase_o = CLASE_STORE;
            OP_R:      clase_o = CLASE_R;
            OP_IMM:    clase_o = CLASE_I;
            OP_BRANCH: clase_o = CLASE_BRANCH;
            OP_JAL:    clase_o = CLASE_JAL;
            OP_LUI:    clase_o = CLASE_LUI;
            default:   clase_o = CLASE_ILEGAL;
        endcase
    end

    assign ilegal_o = (clase_o == CLASE_ILEGAL);

endmodule

// File: rtl/unidad_control_multiciclo.sv
// RV32I multicycle main control FSM. Define UNIDAD_CONTROL_TRAMPA_EN to trap unknown
// opcodes in a sticky TRAMPA state with an excepcion output; otherwise they retire as NOPs.
module unidad_control_multiciclo
    import rv32i_pkg::*;
#(
    parameter int ANCHO_OP = 7
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [ANCHO_OP-1:0] opcode,
    input  logic                mem_listo,
    output logic                lee_mem,
    output logic                escr_mem,
    output logic                sel_dir,
    output logic                escr_ir,
    output logic                escr_pc,
    output logic                rama,
    output logic                escr_reg,
    output logic [1:0]          sel_a,
    output logic [1:0]          sel_b,
    output logic [1:0]          sel_res,
    output logic [1:0]          modo,
    output logic                instr_fin
`ifdef UNIDAD_CONTROL_TRAMPA_EN
    ,
    output logic                excepcion
`endif
);

    estado_e state_q, state_d;
    clase_e  clase;
    logic    ilegal;

    deco_opcode u_deco_opcode (
        .opcode_i (opcode),
        .clase_o  (clase),
        .ilegal_o (ilegal)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INICIO:    state_d = ST_FETCH;
            ST_FETCH:     if (mem_listo) state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (clase)
                    CLASE_LOAD, CLASE_STORE: state_d = ST_MEM_ADDR;
                    CLASE_R:                 state_d = ST_EXEC_R;
                    CLASE_I:                 state_d = ST_EXEC_I;
                    CLASE_BRANCH:            state_d = ST_BRANCH;
                    CLASE_JAL:               state_d = ST_JAL;
                    CLASE_LUI:               state_d = ST_LUI;
`ifdef UNIDAD_CONTROL_TRAMPA_EN
                    default:                 state_d = ST_TRAMPA;
`else
                    default:                 state_d = ST_FETCH;
`endif
                endcase
            end
            // The opcode is held in IR, so the class is still valid here.
            ST_MEM_ADDR:  state_d = (clase == CLASE_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  if (mem_listo) state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: if (mem_listo) state_d = ST_FETCH;
            ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_JAL: state_d = ST_ALU_WB;
            ST_ALU_WB, ST_BRANCH: state_d = ST_FETCH;
            ST_TRAMPA:    state_d = ST_TRAMPA;
            default:      state_d = ST_INICIO;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_INICIO;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode; only the memory-handshake terms look at mem_listo.
    always_comb begin
        lee_mem   = 1'b0;
        escr_mem  = 1'b0;
        sel_dir   = 1'b0;
        escr_ir   = 1'b0;
        escr_pc   = 1'b0;
        rama      = 1'b0;
        escr_reg  = 1'b0;
        sel_a     = SEL_A_PC;
        sel_b     = SEL_B_RS2;
        sel_res   = SEL_RES_ALU_REG;
        modo      = MODO_SUMA;
        instr_fin = 1'b0;
`ifdef UNIDAD_CONTROL_TRAMPA_EN
        excepcion = 1'b0;
`endif
        unique case (state_q)
            ST_FETCH: begin
                lee_mem = 1'b1;
                sel_a   = SEL_A_PC;
                sel_b   = SEL_B_CUATRO;
                sel_res = SEL_RES_ALU;
                escr_ir = mem_listo;
                escr_pc = mem_listo;
            end
            ST_DECODE: begin
                sel_a = SEL_A_PC_ANT;
                sel_b = SEL_B_IMM;
`ifndef UNIDAD_CONTROL_TRAMPA_EN
                instr_fin = ilegal;
`endif
            end
            ST_MEM_ADDR: begin
                sel_a = SEL_A_RS1;
                sel_b = SEL_B_IMM;
            end
            ST_MEM_READ: begin
                sel_dir = 1'b1;
                lee_mem = 1'b1;
            end
            ST_MEM_WB: begin
                sel_res   = SEL_RES_MEM;
                escr_reg  = 1'b1;
                instr_fin = 1'b1;
            end
            ST_MEM_WRITE: begin
                sel_dir   = 1'b1;
                escr_mem  = 1'b1;
                instr_fin = mem_listo;
            end
            ST_EXEC_R: begin
                sel_a = SEL_A_RS1;
                sel_b = SEL_B_RS2;
                modo  = MODO_OP;
            end
            ST_EXEC_I: begin
                sel_a = SEL_A_RS1;
                sel_b = SEL_B_IMM;
                modo  = MODO_OP_IMM;
            end
            ST_LUI: begin
                sel_a = SEL_A_CERO;
                sel_b = SEL_B_IMM;
            end
            ST_JAL: begin
                sel_a   = SEL_A_PC_ANT;
                sel_b   = SEL_B_CUATRO;
                sel_res = SEL_RES_ALU_REG;
                escr_pc = 1'b1;
            end
            ST_ALU_WB: begin
                sel_res   = SEL_RES_ALU_REG;
                escr_reg  = 1'b1;
                instr_fin = 1'b1;
            end
            ST_BRANCH: begin
                sel_a     = SEL_A_RS1;
                sel_b     = SEL_B_RS2;
                modo      = MODO_RAMA;
                sel_res   = SEL_RES_ALU_REG;
                rama      = 1'b1;
                instr_fin = 1'b1;
            end
            ST_TRAMPA: begin
`ifdef UNIDAD_CONTROL_TRAMPA_EN
                excepcion = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: walks each instruction class cycle by cycle
// and compares the full output vector against hand-written per-state values.
module tb_unidad_control_multiciclo;

    logic       clk;
    logic       nreset;
    logic [6:0] opcode;
    logic       mem_listo;
    logic       lee_mem, escr_mem, sel_dir, escr_ir, escr_pc, rama, escr_reg, instr_fin;
    logic [1:0] sel_a, sel_b, sel_res, modo;
    logic       excepcion;

    int errors = 0;
    int checks = 0;

    unidad_control_multiciclo #(.ANCHO_OP(7)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .opcode    (opcode),
        .mem_listo (mem_listo),
        .lee_mem   (lee_mem),
        .escr_mem  (escr_mem),
        .sel_dir   (sel_dir),
        .escr_ir   (escr_ir),
        .escr_pc   (escr_pc),
        .rama      (rama),
        .escr_reg  (escr_reg),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel_res   (sel_res),
        .modo      (modo),
        .instr_fin (instr_fin)
`ifdef UNIDAD_CONTROL_TRAMPA_EN
        ,
        .excepcion (excepcion)
`endif
    );

`ifndef UNIDAD_CONTROL_TRAMPA_EN
    assign excepcion = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {excepcion, lee_mem, escr_mem, sel_dir, escr_ir, escr_pc, rama, escr_reg,
                  sel_a, sel_b, sel_res, modo, instr_fin};

    function automatic logic [16:0] v(input logic exc, lee, em, sd, ir, pc, rm, rg,
                                      input logic [1:0] sa, sb, sr, md, input logic fin);
        return {exc, lee, em, sd, ir, pc, rm, rg, sa, sb, sr, md, fin};
    endfunction

    logic [16:0] e_cero, e_fetch0, e_fetch1, e_decode, e_decode_nop, e_mem_addr, e_mem_read;
    logic [16:0] e_mem_wb, e_mem_wr0, e_mem_wr1, e_exec_r, e_exec_i, e_lui, e_jal;
    logic [16:0] e_alu_wb, e_branch, e_trampa;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] exp);
        #1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        //            exc lee em sd ir pc rm rg  sa     sb     sr     md   fin
        e_cero       = '0;
        e_fetch0     = v(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
        e_fetch1     = v(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
        e_decode     = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        e_decode_nop = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        e_mem_addr   = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
        e_mem_read   = v(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_mem_wb     = v(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 1);
        e_mem_wr0    = v(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_mem_wr1    = v(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        e_exec_r     = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0);
        e_exec_i     = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 0);
        e_lui        = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 0);
        e_jal        = v(0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
        e_alu_wb     = v(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        e_branch     = v(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b11, 1);
        e_trampa     = v(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

        nreset = 1'b0; mem_listo = 1'b0; opcode = 7'd0;
        step(); step();
        chk("reset_all_zero", e_cero);
        nreset = 1'b1;
        chk("inicio_after_release", e_cero);
        step();
        chk("fetch_wait", e_fetch0);
        step();
        chk("fetch_still_wait", e_fetch0);
        mem_listo = 1'b1;
        chk("fetch_listo", e_fetch1);

        // R-type: 4 cycles
        opcode = 7'd51;
        step(); chk("r_decode", e_decode);
        step(); chk("r_exec", e_exec_r);
        step(); chk("r_alu_wb", e_alu_wb);
        step(); chk("r_next_fetch", e_fetch1);
        $display("instr op=51 R retired");

        // OP-IMM
        opcode = 7'd19;
        step(); chk("i_decode", e_decode);
        step(); chk("i_exec", e_exec_i);
        step(); chk("i_alu_wb", e_alu_wb);
        step(); chk("i_next_fetch", e_fetch1);
        $display("instr op=19 OP-IMM retired");

        // Load with three wait cycles in MEM_READ
        opcode = 7'd3;
        step(); chk("ld_decode", e_decode);
        step(); mem_listo = 1'b0; chk("ld_mem_addr_ignores_listo", e_mem_addr);
        step(); chk("ld_read_wait1", e_mem_read);
        step(); chk("ld_read_wait2", e_mem_read);
        step(); chk("ld_read_wait3", e_mem_read);
        mem_listo = 1'b1;
        chk("ld_read_listo", e_mem_read);
        step(); chk("ld_mem_wb", e_mem_wb);
        step(); chk("ld_next_fetch", e_fetch1);
        $display("instr op=3 LOAD retired");

        // Store with one wait cycle
        opcode = 7'd35;
        step(); chk("st_decode", e_decode);
        step(); chk("st_mem_addr", e_mem_addr);
        step(); mem_listo = 1'b0; chk("st_write_wait", e_mem_wr0);
        mem_listo = 1'b1;
        chk("st_write_listo", e_mem_wr1);
        step(); chk("st_next_fetch", e_fetch1);
        $display("instr op=35 STORE retired");

        // Branch: 3 cycles
        opcode = 7'd99;
        step(); chk("br_decode", e_decode);
        step(); chk("br_branch", e_branch);
        step(); chk("br_next_fetch", e_fetch1);
        $display("instr op=99 BRANCH retired");

        // JAL
        opcode = 7'd111;
        step(); chk("jal_decode", e_decode);
        step(); chk("jal_jal", e_jal);
        step(); chk("jal_alu_wb", e_alu_wb);
        step(); chk("jal_next_fetch", e_fetch1);
        $display("instr op=111 JAL retired");

        // LUI
        opcode = 7'd55;
        step(); chk("lui_decode", e_decode);
        step(); chk("lui_lui", e_lui);
        step(); chk("lui_alu_wb", e_alu_wb);
        step(); chk("lui_next_fetch", e_fetch1);
        $display("instr op=55 LUI retired");

        // Reset asserted in the middle of MEM_READ
        opcode = 7'd3;
        step(); chk("rst_ld_decode", e_decode);
        step(); chk("rst_ld_mem_addr", e_mem_addr);
        step(); mem_listo = 1'b0; chk("rst_ld_read", e_mem_read);
        nreset = 1'b0;
        chk("rst_async_drop", e_cero);
        step(); chk("rst_held", e_cero);
        nreset = 1'b1;
        chk("rst_release_inicio", e_cero);
        step(); chk("rst_fetch", e_fetch0);
        mem_listo = 1'b1;
        chk("rst_fetch_listo", e_fetch1);
        $display("reset mid MEM_READ handled");

        // Unknown opcode
        opcode = 7'h7F;
`ifdef UNIDAD_CONTROL_TRAMPA_EN
        step(); chk("ill_decode", e_decode);
        for (int i = 0; i < 10; i++) begin
            step(); chk($sformatf("ill_trampa_%0d", i), e_trampa);
        end
        $display("instr op=127 trapped");
`else
        step(); chk("ill_decode_nop", e_decode_nop);
        step(); chk("ill_next_fetch", e_fetch1);
        $display("instr op=127 retired as NOP");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
